lcd_init_seq: RTL and testbench

LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

---
 rtl/lcd_init_seq.sv | 209 ++++++++++++++++++++
 tb/tb_lcd_init_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: panel power-up sequencer for an SPI-attached LCD.
// Pulses the panel reset, streams a fixed five-entry command table through an
// external SPI master, then forwards single host bytes on request.
// Build option: define LCD_SLEEP_DELAY_EN to insert a WAIT_CYCLES pause after
// the sleep-out command (0x11) before the next table entry is sent.
module lcd_init_seq #(
   parameter int unsigned RST_CYCLES  = 250,
   parameter int unsigned WAIT_CYCLES = 30000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       host_req,
   input  logic       host_dc,
   input  logic [7:0] host_data,
   output logic       host_ack,
   output logic [7:0] spi_data,
   output logic       spi_send,
   input  logic       spi_done,
   output logic       lcd_dc,
   output logic       lcd_res,
   output logic       busy,
   output logic       init_done
);

   localparam int unsigned TBL_LEN  = 5;
   localparam int unsigned IDX_W    = $clog2(TBL_LEN);
   localparam int unsigned CNT_W    = $clog2(RST_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_LEN - 1);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RES_LOW,
      S_RES_WAIT,
      S_LOAD,
      S_SEND,
      S_WAIT_DONE,
      S_READY,
      S_HSEND,
      S_HWAIT
`ifdef LCD_SLEEP_DELAY_EN
      , S_DELAY
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             init_done_q, init_done_d;
   logic             host_ack_q, host_ack_d;
   logic [7:0]       hdata_q, hdata_d;
   logic             hdc_q, hdc_d;
   logic [7:0]       tbl_data;
   logic             tbl_dc;

`ifdef LCD_SLEEP_DELAY_EN
   localparam int unsigned DLY_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(WAIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] SLEEP_IDX = IDX_W'(1);
   logic [DLY_W-1:0] dly_q, dly_d;
`endif

   // Fixed init table lookup: (dc, byte) per index.
   always_comb begin
      tbl_data = '0;
      tbl_dc   = 1'b0;
      case (idx_q)
         IDX_W'(0): tbl_data = 8'h01;
         IDX_W'(1): tbl_data = 8'h11;
         IDX_W'(2): tbl_data = 8'h3A;
         IDX_W'(3): begin tbl_data = 8'h05; tbl_dc = 1'b1; end
         IDX_W'(4): tbl_data = 8'h29;
         default:   tbl_data = '0;
      endcase
   end

   // State and datapath registers; async active-low reset to idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         host_ack_q  <= 1'b0;
         hdata_q     <= '0;
         hdc_q       <= 1'b0;
`ifdef LCD_SLEEP_DELAY_EN
         dly_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         host_ack_q  <= host_ack_d;
         hdata_q     <= hdata_d;
         hdc_q       <= hdc_d;
`ifdef LCD_SLEEP_DELAY_EN
         dly_q       <= dly_d;
`endif
      end
   end

   // Next-state logic: reset pulse timing, table walk, host byte forwarding.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      host_ack_d  = 1'b0;
      hdata_d     = hdata_q;
      hdc_d       = hdc_q;
`ifdef LCD_SLEEP_DELAY_EN
      dly_d       = dly_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RES_LOW;
               cnt_d   = RST_LOAD;
               idx_d   = '0;
            end
         end
         S_RES_LOW: begin
            if (cnt_q == '0) begin
               state_d = S_RES_WAIT;
               cnt_d   = RST_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RES_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_LOAD: state_d = S_SEND;
         S_SEND: state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (spi_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d     = S_READY;
                  init_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
`ifdef LCD_SLEEP_DELAY_EN
                  if (idx_q == SLEEP_IDX) begin
                     state_d = S_DELAY;
                     dly_d   = DLY_LOAD;
                  end else begin
                     state_d = S_LOAD;
                  end
`else
                  state_d = S_LOAD;
`endif
               end
            end
         end
`ifdef LCD_SLEEP_DELAY_EN
         S_DELAY: begin
            if (dly_q == '0) state_d = S_LOAD;
            else             dly_d   = dly_q - 1'b1;
         end
`endif
         // A request is not sampled in the cycle host_ack is high.
         S_READY: begin
            if (init_done_q && host_req && !host_ack_q) begin
               hdata_d = host_data;
               hdc_d   = host_dc;
               state_d = S_HSEND;
            end
         end
         S_HSEND: state_d = S_HWAIT;
         S_HWAIT: begin
            if (spi_done) begin
               host_ack_d = 1'b1;
               state_d    = S_READY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      spi_send  = 1'b0;
      spi_data  = '0;
      lcd_dc    = 1'b0;
      lcd_res   = 1'b1;
      busy      = 1'b1;
      case (state_q)
         S_IDLE:    begin lcd_res = 1'b0; busy = 1'b0; end
         S_RES_LOW: lcd_res = 1'b0;
         S_READY:   busy = 1'b0;
         S_LOAD, S_WAIT_DONE: begin spi_data = tbl_data; lcd_dc = tbl_dc; end
         S_SEND:    begin spi_data = tbl_data; lcd_dc = tbl_dc; spi_send = 1'b1; end
         S_HWAIT:   begin spi_data = hdata_q; lcd_dc = hdc_q; end
         S_HSEND:   begin spi_data = hdata_q; lcd_dc = hdc_q; spi_send = 1'b1; end
         default:   ;
      endcase
      host_ack  = host_ack_q;
      init_done = init_done_q;
   end

endmodule

// File: tb/tb_lcd_init_seq.sv
// tb_lcd_init_seq: directed bench for lcd_init_seq with RST_CYCLES=4,
// WAIT_CYCLES=8 and an SPI master model answering 3 cycles after spi_send.
// Honours LCD_SLEEP_DELAY_EN the same way as the design.
module tb_lcd_init_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       host_req;
   logic       host_dc;
   logic [7:0] host_data;
   logic       host_ack;
   logic [7:0] spi_data;
   logic       spi_send;
   logic       spi_done;
   logic       lcd_dc;
   logic       lcd_res;
   logic       busy;
   logic       init_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int spi_cnt = 0;
   int overlap = 0;
   bit stray_req = 1'b0;
   bit init_seen = 1'b0;
   int init_rise = 0;
   int send_cyc[$];
   logic [7:0] send_data[$];
   logic send_dc[$];
   int done_cyc[$];
   int ack_cyc[$];

   lcd_init_seq #(.RST_CYCLES(4), .WAIT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .start(start), .host_req(host_req),
      .host_dc(host_dc), .host_data(host_data), .host_ack(host_ack),
      .spi_data(spi_data), .spi_send(spi_send), .spi_done(spi_done),
      .lcd_dc(lcd_dc), .lcd_res(lcd_res), .busy(busy), .init_done(init_done)
   );

   always #5 clk = ~clk;

   // One clock cycle: advance, run the SPI model, log observed events.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      spi_done = 1'b0;
      if (spi_cnt > 0) begin
         spi_cnt--;
         if (spi_cnt == 0) begin
            spi_done = 1'b1;
            done_cyc.push_back(cyc);
         end
      end
      if (stray_req) begin
         spi_done  = 1'b1;
         stray_req = 1'b0;
      end
      if (spi_send) begin
         if (spi_cnt > 0) overlap++;
         send_cyc.push_back(cyc);
         send_data.push_back(spi_data);
         send_dc.push_back(lcd_dc);
         spi_cnt = 3;
      end
      if (host_ack) ack_cyc.push_back(cyc);
      if (init_done && !init_seen) begin
         init_seen = 1'b1;
         init_rise = cyc;
      end
   endtask

   task automatic clear_log();
      send_cyc.delete();
      send_data.delete();
      send_dc.delete();
      done_cyc.delete();
      ack_cyc.delete();
      spi_cnt   = 0;
      init_seen = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] outs;
      rst = 1'b0; start = 1'b0; host_req = 1'b0; host_dc = 1'b0;
      host_data = 8'h00; spi_done = 1'b0;
      repeat (3) tick();
      outs = {spi_send, spi_data, lcd_dc, lcd_res, host_ack, busy, init_done};
      checks++;
      if (outs !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0000", outs);
      end
      rst = 1'b1;
      clear_log();
      host_req = 1'b1; host_dc = 1'b1; host_data = 8'h5A;
      stray_req = 1'b1;
      repeat (6) tick();
      host_req = 1'b0;
      checks++;
      if (send_cyc.size() != 0 || busy !== 1'b0 || lcd_res !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores: sends=%0d busy=%b lcd_res=%b expected 0 0 0",
                  send_cyc.size(), busy, lcd_res);
      end
   endtask

   task automatic test_init();
      int t0;
      int n;
      logic [7:0] exp_data [5];
      logic exp_dc [5];
      exp_data = '{8'h01, 8'h11, 8'h3A, 8'h05, 8'h29};
      exp_dc   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      clear_log();
      start = 1'b1; t0 = cyc;
      tick();
      start = 1'b0;
      host_req = 1'b1; host_dc = 1'b1; host_data = 8'hEE;
      while (cyc - t0 < 10) begin
         checks++;
         if (lcd_res !== ((cyc - t0) >= 5)) begin
            errors++;
            $display("FAIL lcd_res_rel%0d: got %b expected %b", cyc - t0, lcd_res, (cyc - t0) >= 5);
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rel%0d: got %b expected 1", cyc - t0, busy);
         end
         start = ((cyc - t0) == 2);
         tick();
      end
      start = 1'b0;
      checks++;
      if (send_cyc.size() != 1 || spi_data !== 8'h01 || lcd_dc !== 1'b0) begin
         errors++;
         $display("FAIL first_send: sends=%0d data=%h dc=%b expected 1 01 0",
                  send_cyc.size(), spi_data, lcd_dc);
      end
      n = 0;
      while (!init_seen && n < 300) begin
         if (cyc - t0 == 25) host_req = 1'b0;
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_init_c%0d: got %b expected 1", cyc - t0, busy);
         end
         tick();
         n++;
      end
      host_req = 1'b0;
      checks++;
      if (!init_seen) begin
         errors++;
         $display("FAIL init_timeout: init_done got 0 expected 1");
         return;
      end
      checks++;
      if (send_cyc.size() != 5) begin
         errors++;
         $display("FAIL init_send_count: got %0d expected 5", send_cyc.size());
         return;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (send_data[i] !== exp_data[i] || send_dc[i] !== exp_dc[i]) begin
            errors++;
            $display("FAIL init_entry%0d: got %b/%h expected %b/%h", i,
                     send_dc[i], send_data[i], exp_dc[i], exp_data[i]);
         end
      end
      checks++;
      if (send_cyc[0] != t0 + 10) begin
         errors++;
         $display("FAIL first_send_cycle: got %0d expected 10", send_cyc[0] - t0);
      end
      checks++;
`ifdef LCD_SLEEP_DELAY_EN
      if (send_cyc[2] - done_cyc[1] < 8 || send_cyc[4] != t0 + 38) begin
         errors++;
         $display("FAIL sleep_gap: gap=%0d last=%0d expected >=8 38",
                  send_cyc[2] - done_cyc[1], send_cyc[4] - t0);
      end
`else
      if (send_cyc[2] - done_cyc[1] != 2 || send_cyc[4] != t0 + 30) begin
         errors++;
         $display("FAIL sleep_gap: gap=%0d last=%0d expected 2 30",
                  send_cyc[2] - done_cyc[1], send_cyc[4] - t0);
      end
`endif
      checks++;
      if (init_rise != done_cyc[4] + 1) begin
         errors++;
         $display("FAIL init_done_edge: got %0d expected %0d", init_rise, done_cyc[4] + 1);
      end
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0 || init_done !== 1'b1 || ack_cyc.size() != 0 || overlap != 0) begin
         errors++;
         $display("FAIL ready_state: busy=%b init_done=%b acks=%0d overlap=%0d expected 0 1 0 0",
                  busy, init_done, ack_cyc.size(), overlap);
      end
   endtask

   task automatic test_host();
      int r;
      int n;
      clear_log();
      stray_req = 1'b1;
      repeat (5) tick();
      checks++;
      if (send_cyc.size() != 0 || ack_cyc.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_done: sends=%0d acks=%0d busy=%b expected 0 0 0",
                  send_cyc.size(), ack_cyc.size(), busy);
      end
      host_req = 1'b1; host_dc = 1'b1; host_data = 8'hA5; r = cyc;
      n = 0;
      while (ack_cyc.size() < 2 && n < 50) begin
         tick();
         n++;
         if (cyc == r + 2) begin
            checks++;
            if (busy !== 1'b1 || spi_data !== 8'hA5 || lcd_dc !== 1'b1) begin
               errors++;
               $display("FAIL hwait_hold: busy=%b data=%h dc=%b expected 1 a5 1", busy, spi_data, lcd_dc);
            end
         end
      end
      host_req = 1'b0;
      repeat (6) tick();
      checks++;
      if (send_cyc.size() != 2 || ack_cyc.size() != 2) begin
         errors++;
         $display("FAIL host_counts: sends=%0d acks=%0d expected 2 2", send_cyc.size(), ack_cyc.size());
         return;
      end
      checks++;
      if (send_cyc[0] != r + 1 || send_data[0] !== 8'hA5 || send_dc[0] !== 1'b1) begin
         errors++;
         $display("FAIL host_send0: cyc=%0d data=%h dc=%b expected 1 a5 1",
                  send_cyc[0] - r, send_data[0], send_dc[0]);
      end
      checks++;
      if (ack_cyc[0] != done_cyc[0] + 1 || ack_cyc[0] != r + 5) begin
         errors++;
         $display("FAIL host_ack0: got %0d expected 5", ack_cyc[0] - r);
      end
      checks++;
      if (send_cyc[1] != r + 7 || ack_cyc[1] != r + 11) begin
         errors++;
         $display("FAIL host_second: send=%0d ack=%0d expected 7 11",
                  send_cyc[1] - r, ack_cyc[1] - r);
      end
      host_req = 1'b1; host_dc = 1'b0; host_data = 8'h3C;
      tick();
      host_req = 1'b0;
      repeat (8) tick();
      checks++;
      if (send_cyc.size() != 3 || ack_cyc.size() != 3 || overlap != 0) begin
         errors++;
         $display("FAIL host_cmd_count: sends=%0d acks=%0d overlap=%0d expected 3 3 0",
                  send_cyc.size(), ack_cyc.size(), overlap);
      end else begin
         checks++;
         if (send_data[2] !== 8'h3C || send_dc[2] !== 1'b0) begin
            errors++;
            $display("FAIL host_cmd: got %b/%h expected 0/3c", send_dc[2], send_data[2]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int t0;
      int n;
      logic [13:0] outs;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      clear_log();
      tick();
      start = 1'b1; t0 = cyc;
      tick();
      start = 1'b0;
      n = 0;
      while (send_cyc.size() < 4 && n < 100) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (spi_data !== 8'h05 || lcd_dc !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL wait_done_entry3: data=%h dc=%b busy=%b expected 05 1 1", spi_data, lcd_dc, busy);
      end
      #2;
      rst = 1'b0;
      #1;
      outs = {spi_send, spi_data, lcd_dc, lcd_res, host_ack, busy, init_done};
      checks++;
      if (outs !== 14'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got %h expected 0000", outs);
      end
      spi_cnt = 0;
      repeat (2) tick();
      rst = 1'b1;
      clear_log();
      repeat (20) tick();
      checks++;
      if (send_cyc.size() != 0 || busy !== 1'b0 || lcd_res !== 1'b0) begin
         errors++;
         $display("FAIL no_restart: sends=%0d busy=%b lcd_res=%b expected 0 0 0",
                  send_cyc.size(), busy, lcd_res);
      end
      start = 1'b1; t0 = cyc;
      tick();
      start = 1'b0;
      n = 0;
      while (!init_seen && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (!init_seen || send_cyc.size() != 5) begin
         errors++;
         $display("FAIL restart_init: init_done=%b sends=%0d expected 1 5", init_seen, send_cyc.size());
      end else begin
         checks++;
         if (send_cyc[0] != t0 + 10 || send_data[0] !== 8'h01) begin
            errors++;
            $display("FAIL restart_first: cyc=%0d data=%h expected 10 01",
                     send_cyc[0] - t0, send_data[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_host();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
